// File: rtl/vball_vram_arbiter.sv
// VBall video-RAM arbiter: one synchronous tile/attribute RAM shared between the
// CPU (level req / ack pulse) and the background fetch engine, slotted on blanking and hcount.
module vball_vram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [8:0]    hcount,
  input  logic          hb,
  input  logic          vb,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_dout,
  output logic          vid_valid,
  output logic          vid_ovf,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // state  | meaning
  // IDLE   | no CPU request outstanding
  // WAIT   | request seen, eligible for a RAM slot
  // ISSUED | RAM access in flight, ack and read data registered this cycle
  // DONE   | ack given, waiting for cpu_req to drop
  typedef enum logic [1:0] {IDLE, WAIT, ISSUED, DONE} cpu_state_t;

  cpu_state_t    state;
  cpu_state_t    state_nxt;

  logic          vid_pend;
  logic [AW-1:0] vid_pend_addr;
  logic          vid_owner;
  logic          cpu_elig;
  logic          grant_vid;
  logic          grant_cpu;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          issued_we;
  logic          vid_valid_q;
  logic [DW-1:0] vid_dout_q;
  logic          hcount_unused;

  // Only the slot parity matters, so the hcount wrap needs no special handling.
  assign hcount_unused = ^hcount[8:1];

  assign vid_owner = ~hb & ~vb & ~hcount[0];
  assign cpu_elig  = (state == WAIT);

  // Owner first, otherwise the other side may borrow the slot; never both.
  assign grant_vid = vid_pend & (vid_owner | ~cpu_elig);
  assign grant_cpu = cpu_elig & (~vid_owner | ~vid_pend);

  always_comb begin
    ram_addr = addr_q;
    ram_we   = 1'b0;
    ram_din  = din_q;
    if (grant_cpu) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      ram_din  = cpu_din;
    end else if (grant_vid) begin
      ram_addr = vid_pend_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = WAIT;
      WAIT:    if (grant_cpu) state_nxt = ISSUED;
      ISSUED:  state_nxt = DONE;
      DONE:    if (!cpu_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= '0;
      din_q         <= '0;
      vid_pend      <= 1'b0;
      vid_pend_addr <= '0;
      vid_ovf       <= 1'b0;
    end else begin
      addr_q <= ram_addr;
      din_q  <= ram_din;
      // A pulse in the same cycle the pending entry is granted takes its place.
      if (vid_req && (!vid_pend || grant_vid)) begin
        vid_pend      <= 1'b1;
        vid_pend_addr <= vid_addr;
      end else if (grant_vid) begin
        vid_pend <= 1'b0;
      end
      if (vid_req && vid_pend && !grant_vid) begin
        vid_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_we   <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      vid_valid_q <= 1'b0;
      vid_dout_q  <= '0;
    end else begin
      if (grant_cpu) begin
        issued_we <= cpu_we;
      end
      cpu_ack <= (state == ISSUED);
      if ((state == ISSUED) && !issued_we) begin
        cpu_dout <= ram_dout;
      end
      vid_valid_q <= grant_vid;
      if (vid_valid_q) begin
        vid_dout_q <= ram_dout;
      end
    end
  end

  // Fetch data is passed straight from the RAM in the valid cycle, then held.
  assign vid_valid = vid_valid_q;
  assign vid_dout  = vid_valid_q ? ram_dout : vid_dout_q;

endmodule

// File: tb/tb_vball_vram_arbiter.sv
// Directed bench for vball_vram_arbiter with a RAM model and CPU/video scoreboards.
module tb_vball_vram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [8:0]    hcount = '0;
  logic          hb = 1'b1;
  logic          vb = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_dout;
  logic          vid_valid;
  logic          vid_ovf;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  vball_vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .hb(hb), .vb(vb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .vid_valid(vid_valid), .vid_ovf(vid_ovf),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input logic [11:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Synchronous RAM model; unwritten locations read back a fixed address pattern.
  logic [DW-1:0] mem [0:4095];
  logic          written [0:4095];
  logic          ram_ready = 1'b0;
  logic [DW-1:0] ram_q = '0;
  assign ram_dout = ram_q;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
      ram_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr]     <= ram_din;
      written[ram_addr] <= 1'b1;
    end
    ram_q <= (ram_ready && written[ram_addr]) ? mem[ram_addr] : pattern(ram_addr);
  end

  typedef struct {
    logic       we;
    logic [7:0] data;
    int         t0;
    int         lat;
  } cpu_exp_t;

  typedef struct {
    logic [7:0] data;
    int         t0;
    int         lat;
  } vid_exp_t;

  cpu_exp_t cpu_q[$];
  vid_exp_t vid_q[$];

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc_n = 0;
  int   ack_cnt = 0;
  int   we_cnt = 0;
  int   vv_cnt = 0;
  logic ack_now = 1'b0;
  logic auto_drop = 1'b1;
  logic chk_even = 1'b0;
  logic [8:0] prev_hc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Sample the current cycle at the falling edge, then advance into the next cycle.
  task automatic cyc();
    cpu_exp_t ce;
    vid_exp_t ve;
    @(negedge clk);
    ack_now = cpu_ack;
    if (ram_we) we_cnt++;
    if (cpu_ack) begin
      ack_cnt++;
      if (cpu_q.size() == 0) begin
        check("cpu_ack_spurious", {31'd0, cpu_ack}, 32'd0);
      end else begin
        ce = cpu_q.pop_front();
        check("cpu_ack_latency", cyc_n - ce.t0, ce.lat);
        if (!ce.we) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, ce.data});
      end
    end
    if (vid_valid) begin
      vv_cnt++;
      if (vid_q.size() == 0) begin
        check("vid_valid_spurious", {31'd0, vid_valid}, 32'd0);
      end else begin
        ve = vid_q.pop_front();
        check("vid_latency", cyc_n - ve.t0, ve.lat);
        check("vid_dout", {24'd0, vid_dout}, {24'd0, ve.data});
      end
      if (chk_even) check("vid_grant_even_slot", {31'd0, prev_hc[0]}, 32'd0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    prev_hc = hcount;
    hcount  = (hcount == 9'd399) ? 9'd0 : hcount + 9'd1;
    if (ack_now && auto_drop) cpu_req = 1'b0;
  endtask

  task automatic cpu_start(input logic we, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] exp_data, input int lat, input logic push);
    cpu_exp_t ce;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    ce.we = we; ce.data = exp_data; ce.t0 = cyc_n; ce.lat = lat;
    if (push) cpu_q.push_back(ce);
  endtask

  task automatic cpu_wait();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      cyc();
      got = ack_now;
    end
    check("cpu_ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic vid_pulse(input logic [11:0] a, input int lat);
    vid_exp_t ve;
    vid_req  = 1'b1;
    vid_addr = a;
    ve.data = pattern(a); ve.t0 = cyc_n; ve.lat = lat;
    vid_q.push_back(ve);
  endtask

  initial begin
    int we0, a0, v0;

    // Reset state
    cyc();
    check("rst_cpu_ack",   {31'd0, cpu_ack},   32'd0);
    check("rst_vid_valid", {31'd0, vid_valid}, 32'd0);
    check("rst_vid_ovf",   {31'd0, vid_ovf},   32'd0);
    check("rst_ram_we",    {31'd0, ram_we},    32'd0);
    check("rst_outs_zero", {cpu_dout, vid_dout, ram_din, 4'd0, ram_addr}, 32'd0);
    reset_n = 1'b1;
    cyc();
    cyc();

    // Blanking: write 0x5A to 0x123, then read it back
    we0 = we_cnt;
    cpu_start(1'b1, 12'h123, 8'h5A, 8'h00, 3, 1'b1);
    cpu_wait();
    cyc();
    check("blank_write_we_cycles", we_cnt - we0, 1);
    we0 = we_cnt;
    cpu_start(1'b0, 12'h123, 8'h00, 8'h5A, 3, 1'b1);
    cpu_wait();
    cyc();
    check("blank_read_we_cycles", we_cnt - we0, 0);

    // Active display: video every other cycle with a CPU read held high
    hb = 1'b0; vb = 1'b0;
    cyc();
    while (hcount[0] == 1'b0) cyc();
    chk_even = 1'b1;
    a0 = ack_cnt; v0 = vv_cnt;
    cpu_start(1'b0, 12'h123, 8'h00, 8'h5A, 4, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (hcount[0]) vid_pulse(12'h200 + 12'(i), 2);
      else vid_req = 1'b0;
      cyc();
    end
    vid_req = 1'b0;
    repeat (4) cyc();
    chk_even = 1'b0;
    check("active_ack_count", ack_cnt - a0, 1);
    check("active_vid_count", vv_cnt - v0, 4);

    // Active display: two consecutive fetches, CPU idle, second borrows the odd slot
    while (hcount[0] == 1'b0) cyc();
    v0 = vv_cnt;
    vid_pulse(12'h210, 2);
    cyc();
    vid_pulse(12'h211, 2);
    cyc();
    vid_req = 1'b0;
    repeat (4) cyc();
    check("borrow_vid_count", vv_cnt - v0, 2);
    check("borrow_no_ovf", {31'd0, vid_ovf}, 32'd0);

    // Three back-to-back fetches while the CPU holds the odd slot: third dropped
    while (hcount[0] == 1'b0) cyc();
    v0 = vv_cnt;
    vid_pulse(12'h220, 2);
    cyc();
    vid_pulse(12'h221, 3);
    cpu_start(1'b0, 12'h123, 8'h00, 8'h5A, 3, 1'b1);
    cyc();
    vid_req  = 1'b1;
    vid_addr = 12'h222;
    cyc();
    vid_req = 1'b0;
    cpu_wait();
    cyc();
    repeat (3) cyc();
    check("drop_vid_count", vv_cnt - v0, 2);
    check("drop_ovf_set", {31'd0, vid_ovf}, 32'd1);

    // Blanking: request held 10 cycles past ack gives one access only
    hb = 1'b1; vb = 1'b1;
    auto_drop = 1'b0;
    we0 = we_cnt; a0 = ack_cnt;
    cpu_start(1'b1, 12'h300, 8'h77, 8'h00, 3, 1'b1);
    cpu_wait();
    repeat (10) cyc();
    cpu_req = 1'b0;
    cyc();
    cyc();
    auto_drop = 1'b1;
    check("held_ack_count", ack_cnt - a0, 1);
    check("held_we_count", we_cnt - we0, 1);
    check("ovf_sticky", {31'd0, vid_ovf}, 32'd1);
    cpu_start(1'b0, 12'h300, 8'h00, 8'h77, 3, 1'b1);
    cpu_wait();
    cyc();

    // Reset asserted in the ISSUED cycle
    a0 = ack_cnt;
    cpu_start(1'b0, 12'h123, 8'h00, 8'h5A, 3, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b0;
    #1;
    check("midrst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("midrst_ovf",     {31'd0, vid_ovf}, 32'd0);
    check("midrst_ram_we",  {31'd0, ram_we},  32'd0);
    check("midrst_outs_zero", {cpu_dout, vid_dout, ram_din, 4'd0, ram_addr}, 32'd0);
    cpu_req = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    check("midrst_no_ack", ack_cnt - a0, 0);
    check("midrst_ovf_after", {31'd0, vid_ovf}, 32'd0);
    cpu_start(1'b0, 12'h123, 8'h00, 8'h5A, 3, 1'b1);
    cpu_wait();
    cyc();
    repeat (2) cyc();

    check("cpu_q_drained", cpu_q.size(), 0);
    check("vid_q_drained", vid_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
